// File: rtl/argmax_classifier_if.sv
// Stream bundle for argmax_classifier: word input (valid/ready) and
// class-index output (valid/ready).
// Optional build macro ARGMAX_VAL_OUT_EN adds the max_out value signal.
interface argmax_classifier_if #(
  parameter int M = 10,
  parameter int T = 9
);
  localparam int logM = $clog2(M);

  logic                   s_valid;
  logic                   s_ready;
  logic signed [T-1:0]    data_in;
  logic                   m_valid;
  logic                   m_ready;
  logic        [logM-1:0] data_out;
`ifdef ARGMAX_VAL_OUT_EN
  logic signed [T-1:0]    max_out;
`endif

`ifdef ARGMAX_VAL_OUT_EN
  // Environment side: produces words, consumes results
  modport master (
    output s_valid, data_in, m_ready,
    input  s_ready, m_valid, data_out, max_out
  );
  // Classifier side
  modport slave (
    input  s_valid, data_in, m_ready,
    output s_ready, m_valid, data_out, max_out
  );
`else
  // Environment side: produces words, consumes results
  modport master (
    output s_valid, data_in, m_ready,
    input  s_ready, m_valid, data_out
  );
  // Classifier side
  modport slave (
    input  s_valid, data_in, m_ready,
    output s_ready, m_valid, data_out
  );
`endif
endinterface

// File: rtl/argmax_classifier.sv
// argmax_classifier: consumes M signed T-bit words per vector and emits the
// index of the largest word (ties keep the lowest index).
// Optional build macro ARGMAX_VAL_OUT_EN also exports the maximum value on
// max_out with the same timing as data_out.
module argmax_classifier #(
  parameter int M = 10,
  parameter int T = 9,
  localparam int logM = $clog2(M)
) (
  input logic         clk,
  input logic         reset,
  argmax_classifier_if.slave bus
);
  localparam logic [logM-1:0] LAST_IDX = logM'(M - 1);

  typedef enum logic {ACC = 1'b0, OUT = 1'b1} state_t;

  state_t              state_reg;
  state_t              state_next;
  logic                run_reg;
  logic                accept;
  logic                take_new;
  logic [logM-1:0]     count_reg;
  logic [logM-1:0]     best_idx_reg;
  logic [logM-1:0]     idx_out_reg;
  logic [logM-1:0]     cand_idx;
  logic signed [T-1:0] best_val_reg;
  logic signed [T-1:0] cand_val;
`ifdef ARGMAX_VAL_OUT_EN
  logic signed [T-1:0] val_out_reg;
`endif

  // Keep the input closed while in reset; open it from the first edge after release
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) run_reg <= 1'b0;
    else        run_reg <= 1'b1;
  end

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_reg <= ACC;
    else        state_reg <= state_next;
  end

  // Next state and accept decode; s_ready depends only on registered state
  always_comb begin
    state_next = state_reg;
    accept     = 1'b0;
    case (state_reg)
      ACC: begin
        if (run_reg && bus.s_valid) begin
          accept = 1'b1;
          if (count_reg == LAST_IDX) state_next = OUT;
        end
      end
      OUT: begin
        if (bus.m_ready) state_next = ACC;
      end
      default: state_next = ACC;
    endcase
  end

  // Candidate running max: first word of a vector always loads, later words
  // replace only when strictly greater so ties keep the lower index
  always_comb begin
    take_new = (count_reg == '0) || ($signed(bus.data_in) > best_val_reg);
    cand_idx = take_new ? count_reg   : best_idx_reg;
    cand_val = take_new ? bus.data_in : best_val_reg;
  end

  // Running max, word counter, and result registers loaded on the last word
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count_reg    <= '0;
      best_idx_reg <= '0;
      best_val_reg <= '0;
      idx_out_reg  <= '0;
`ifdef ARGMAX_VAL_OUT_EN
      val_out_reg  <= '0;
`endif
    end else if (accept) begin
      best_idx_reg <= cand_idx;
      best_val_reg <= cand_val;
      if (count_reg == LAST_IDX) begin
        count_reg   <= '0;
        idx_out_reg <= cand_idx;
`ifdef ARGMAX_VAL_OUT_EN
        val_out_reg <= cand_val;
`endif
      end else begin
        count_reg <= count_reg + logM'(1);
      end
    end
  end

  assign bus.s_ready  = run_reg && (state_reg == ACC);
  assign bus.m_valid  = (state_reg == OUT);
  assign bus.data_out = idx_out_reg;
`ifdef ARGMAX_VAL_OUT_EN
  assign bus.max_out  = val_out_reg;
`endif

endmodule

// File: doc/argmax_classifier.md
Name: argmax_classifier

Overview:
- Output stage placed directly downstream of a fully-connected layer block (for example, the 10-output, 9-bit layer).
- Consumes the layer's serial output vector of M signed T-bit words over a valid/ready stream.
- Tracks the running maximum and emits one class index per vector, also over valid/ready.
- Serves as the final classification stage of the network pipeline.

Parameters:
M, 10, number of words per input vector (layer output count), M >= 2
T, 9, input word width in bits, signed two's complement
logM, $clog2(M), width of the class index and the word counter (derived, do not override)

Ports:
clk  input  1  clock, rising edge
reset  input  1  asynchronous, active-low reset (asserted when 0)
s_valid  input  1  upstream word valid
s_ready  output  1  block can accept a word this cycle
data_in  input  T  signed input word (layer output y[k])
m_valid  output  1  class result valid
m_ready  input  1  downstream accepts result
data_out  output  logM  index k (0..M-1) of the maximum word in the last vector

Behaviour:
- Reset (reset==0, asynchronous):
  - state=ACC, count=0, best_idx=0, best_val=0.
  - m_valid=0, data_out=0, s_ready=0 while reset is held.
  - On deassertion, s_ready=1 from the first clock edge onward.
- Accept event: s_valid && s_ready at a rising edge. Transfer event: m_valid && m_ready at a rising edge.
- State ACC:
  - s_ready=1, m_valid=0.
  - On each accept with count==0: best_val<=data_in, best_idx<=0.
  - On each accept with count>0: if $signed(data_in) > best_val (strict), best_val<=data_in and best_idx<=count.
  - Ties keep the lower index.
  - count<=count+1 on each accept.
  - On the accept where count==M-1, the comparison uses that last word, count<=0, and the next state is OUT.
- State OUT:
  - s_ready=0, m_valid=1.
  - data_out=best_idx, registered and stable while m_valid && !m_ready.
  - On transfer: state<=ACC, m_valid<=0.
- Latency: m_valid rises on the clock edge that accepts word M-1, i.e. it is visible in the cycle immediately after the last data beat.
- Throughput: one vector per M+1 cycles minimum (M accept cycles plus 1 output cycle when m_ready is held high).
- s_ready is combinational from state only. It never depends on s_valid or m_ready, so there are no combinational loops with neighbouring stages.
- Cycles with s_valid==0 in ACC leave all registers unchanged. Gaps inside a vector are allowed.
- The counter never exceeds M-1. It wraps to 0 only at end of vector.
- Negative words are compared as signed. An all-negative vector reports the index of the least-negative word.
- An all-equal vector reports index 0.
- Reset asserted mid-vector or during OUT discards the partial or pending result immediately. No output is produced for that vector.
- data_out holds its last value after transfer until the next result is loaded. Verification must check data_out only while m_valid==1.

Optional Feature:
ARGMAX_VAL_OUT_EN
- Defined:
  - Adds output port max_out (output, T bits, signed), driven from best_val.
  - Registered with the same timing and hold rules as data_out.
  - Reset value 0.
- Undefined:
  - Port is absent.
  - best_val remains internal.
  - Index behaviour is identical in both builds.

Test Plan:
- Single vector, m_ready=1, inputs 3,0,-5,7,2,1,0,6,4,2 -> m_valid exactly one cycle after the 10th accept, data_out=3 (max_out=7 if enabled), then s_ready=1 next cycle.
- Ties and all-negative: vector -4,-2,-9,-2,-8,-3,-2,-7,-6,-5 -> data_out=1 (lowest index among the three -2 entries); vector of ten 5s -> data_out=0.
- Backpressure: complete a vector with max at index 9 (value 255), hold m_ready=0 for 6 cycles -> m_valid and data_out=9 stable, s_ready=0 throughout, s_valid pulses ignored; raise m_ready -> one transfer, s_ready=1 next cycle.
- Bubbles: random s_valid gaps (about 50% duty) across 3 back-to-back vectors with maxima at indices 0, 5, 9 -> results 0, 5, 9 in order, no word lost or double-counted.
- Async reset: drive reset=0 between clock edges after 4 accepted words -> m_valid=0 and data_out=0 immediately; after release, a fresh vector with max at index 2 -> data_out=2 (no carry-over from the discarded words).
- Boundary value: words -256 (minimum T=9 value) at index 0 and 255 at index 8 -> data_out=8, confirming signed compare at full range.
